// File: rtl/ex_muldiv_if.sv
// Request/result bundle between the EX stage pipeline and the multiply/divide unit.
// master = pipeline side (drives the op), slave = ex_muldiv.
interface ex_muldiv_if #(
    parameter int unsigned DATA_W = 32
);
    logic              refresh;
    logic              pipe_hold;
    logic              ex_mult;
    logic              ex_div;
    logic              ex_mdsign;
    logic [DATA_W-1:0] ex_A;
    logic [DATA_W-1:0] ex_B;
    logic              md_stall;
    logic              md_valid;
    logic [DATA_W-1:0] md_hi;
    logic [DATA_W-1:0] md_lo;

    modport master (
        output refresh, pipe_hold, ex_mult, ex_div, ex_mdsign, ex_A, ex_B,
        input  md_stall, md_valid, md_hi, md_lo
    );

    modport slave (
        input  refresh, pipe_hold, ex_mult, ex_div, ex_mdsign, ex_A, ex_B,
        output md_stall, md_valid, md_hi, md_lo
    );
endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT(U)/DIV(U) unit for the EX stage: iterative shift-add / restoring divide.
// Define MDU_FAST_MULT_EN to compute multiplies in one MUL cycle with the '*' operator.
module ex_muldiv #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input logic         clk,
    input logic         resetn,
    ex_muldiv_if.slave  md
);

`ifdef MDU_FAST_MULT_EN
    typedef enum logic [1:0] {StIdle, StCalc, StDone, StMul} state_e;
`else
    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;
`endif

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    // Divide: acc_hi = partial remainder, acc_lo = dividend/quotient shift register.
    // Multiply: acc_hi = upper product, acc_lo = multiplier/lower product.
    logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
    logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [DATA_W-1:0] md_hi_q, md_hi_d;
    logic [DATA_W-1:0] md_lo_q, md_lo_d;

    logic              req;
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W:0]   rem_sh, rem_sub, mul_sum;
    logic [DATA_W-1:0] calc_hi, calc_lo;
    logic [DATA_W-1:0] fix_hi, fix_lo;
    logic [2*DATA_W-1:0] prod_fix;
`ifdef MDU_FAST_MULT_EN
    logic [2*DATA_W-1:0] prod_fast, prod_fast_fix;
`endif

    always_comb begin
        req   = md.ex_mult | md.ex_div;
        a_neg = md.ex_mdsign & md.ex_A[DATA_W-1];
        b_neg = md.ex_mdsign & md.ex_B[DATA_W-1];
        // 0x80000000 negates to itself, which reads correctly as magnitude 2^31.
        a_mag = a_neg ? -md.ex_A : md.ex_A;
        b_mag = b_neg ? -md.ex_B : md.ex_B;

        rem_sh  = {acc_hi_q, acc_lo_q[DATA_W-1]};
        rem_sub = rem_sh - {1'b0, opnd_q};
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

        if (is_div_q) begin
            if (!rem_sub[DATA_W]) begin
                calc_hi = rem_sub[DATA_W-1:0];
                calc_lo = {acc_lo_q[DATA_W-2:0], 1'b1};
            end else begin
                calc_hi = rem_sh[DATA_W-1:0];
                calc_lo = {acc_lo_q[DATA_W-2:0], 1'b0};
            end
        end else begin
            calc_hi = mul_sum[DATA_W:1];
            calc_lo = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
        end

        prod_fix = neg_res_q ? -{calc_hi, calc_lo} : {calc_hi, calc_lo};
        if (is_div_q) begin
            fix_hi = neg_rem_q ? -calc_hi : calc_hi;
            fix_lo = neg_res_q ? -calc_lo : calc_lo;
        end else begin
            fix_hi = prod_fix[2*DATA_W-1:DATA_W];
            fix_lo = prod_fix[DATA_W-1:0];
        end

`ifdef MDU_FAST_MULT_EN
        prod_fast     = {{DATA_W{1'b0}}, opnd_q} * {{DATA_W{1'b0}}, acc_lo_q};
        prod_fast_fix = neg_res_q ? -prod_fast : prod_fast;
`endif
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        md_hi_d   = md_hi_q;
        md_lo_d   = md_lo_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    is_div_d  = md.ex_div;
                    acc_hi_d  = '0;
                    count_d   = '0;
                    neg_res_d = a_neg ^ b_neg;
                    if (md.ex_div) begin
                        acc_lo_d  = a_mag;
                        opnd_d    = b_mag;
                        neg_rem_d = a_neg;
                        state_d   = StCalc;
                    end else begin
                        acc_lo_d  = b_mag;
                        opnd_d    = a_mag;
                        neg_rem_d = a_neg ^ b_neg;
`ifdef MDU_FAST_MULT_EN
                        state_d   = StMul;
`else
                        state_d   = StCalc;
`endif
                    end
                end
            end
            StCalc: begin
                count_d  = count_q + CNT_W'(1);
                acc_hi_d = calc_hi;
                acc_lo_d = calc_lo;
                if (count_q == LastCnt) begin
                    md_hi_d = fix_hi;
                    md_lo_d = fix_lo;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!md.pipe_hold) begin
                    state_d = StIdle;
                end
            end
`ifdef MDU_FAST_MULT_EN
            StMul: begin
                md_hi_d = prod_fast_fix[2*DATA_W-1:DATA_W];
                md_lo_d = prod_fast_fix[DATA_W-1:0];
                state_d = StDone;
            end
`endif
            default: state_d = StIdle;
        endcase

        // A flush abandons the op without touching the visible result.
        if (md.refresh) begin
            state_d = StIdle;
            md_hi_d = md_hi_q;
            md_lo_d = md_lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            count_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            md_hi_q   <= '0;
            md_lo_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            md_hi_q   <= md_hi_d;
            md_lo_q   <= md_lo_d;
        end
    end

    always_comb begin
        md.md_stall = resetn & (((state_q == StIdle) & req) | (state_q == StCalc)
`ifdef MDU_FAST_MULT_EN
                               | (state_q == StMul)
`endif
                               );
        md.md_valid = resetn & (state_q == StDone) & ~md.refresh;
        md.md_hi    = md_hi_q;
        md.md_lo    = md_lo_q;
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: values, stall/valid timing, refresh abort and pipe_hold.
module tb_ex_muldiv;

`ifdef MDU_FAST_MULT_EN
    localparam int MulLat = 2;
`else
    localparam int MulLat = 33;
`endif
    localparam int DivLat = 33;

    logic clk;
    logic resetn;
    int   nvec;
    int   nerr;

    ex_muldiv_if #(.DATA_W(32)) md_if ();

    ex_muldiv #(.DATA_W(32), .CNT_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .md     (md_if)
    );

    always #5 clk = ~clk;

    task automatic start_op(input logic dv, input logic ml, input logic sg,
                            input logic [31:0] a, input logic [31:0] b);
        md_if.ex_div    = dv;
        md_if.ex_mult   = ml;
        md_if.ex_mdsign = sg;
        md_if.ex_A      = a;
        md_if.ex_B      = b;
    endtask

    task automatic clear_req();
        md_if.ex_div  = 1'b0;
        md_if.ex_mult = 1'b0;
    endtask

    // Called at posedge+1; returns at the negedge of the first md_valid cycle (or on timeout).
    task automatic wait_valid(output int vcyc, output int nstall);
        vcyc   = -1;
        nstall = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (md_if.md_stall) nstall++;
            if (md_if.md_valid) begin
                vcyc = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_op(input logic dv, input logic ml, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         output int vcyc, output int nstall,
                         output logic [31:0] hi, output logic [31:0] lo);
        hi = 'x;
        lo = 'x;
        start_op(dv, ml, sg, a, b);
        wait_valid(vcyc, nstall);
        if (vcyc >= 0) begin
            hi = md_if.md_hi;
            lo = md_if.md_lo;
        end
        @(posedge clk); #1;
        clear_req();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start_op(1'b1, 1'b0, 1'b1, 32'd100, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        nvec++; if (md_if.md_stall !== 1'b0) begin nerr++; $display("FAIL reset_stall got %b want 0", md_if.md_stall); end
        nvec++; if (md_if.md_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", md_if.md_valid); end
        nvec++; if (md_if.md_hi !== 32'h0) begin nerr++; $display("FAIL reset_hi got %h want 0", md_if.md_hi); end
        nvec++; if (md_if.md_lo !== 32'h0) begin nerr++; $display("FAIL reset_lo got %h want 0", md_if.md_lo); end
        @(posedge clk); #1;
        resetn = 1'b1;
        clear_req();
        @(negedge clk);
        nvec++; if (md_if.md_stall !== 1'b0) begin nerr++; $display("FAIL idle_stall got %b want 0", md_if.md_stall); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_signed();
        int v, s;
        logic [31:0] hi, lo;
        do_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, v, s, hi, lo);
        nvec++; if (s !== DivLat) begin nerr++; $display("FAIL div_s stall_cycles got %0d want %0d", s, DivLat); end
        nvec++; if (v !== DivLat) begin nerr++; $display("FAIL div_s valid_cycle got %0d want %0d", v, DivLat); end
        nvec++; if (lo !== 32'hFFFF_FFFD) begin nerr++; $display("FAIL div_s lo got %h want fffffffd", lo); end
        nvec++; if (hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL div_s hi got %h want ffffffff", hi); end
    endtask

    task automatic test_multu();
        int v, s;
        logic [31:0] hi, lo;
        do_op(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, v, s, hi, lo);
        nvec++; if (s !== MulLat) begin nerr++; $display("FAIL multu stall_cycles got %0d want %0d", s, MulLat); end
        nvec++; if (v !== MulLat) begin nerr++; $display("FAIL multu valid_cycle got %0d want %0d", v, MulLat); end
        nvec++; if (hi !== 32'hFFFF_FFFE) begin nerr++; $display("FAIL multu hi got %h want fffffffe", hi); end
        nvec++; if (lo !== 32'h0000_0001) begin nerr++; $display("FAIL multu lo got %h want 00000001", lo); end
    endtask

    task automatic test_mult_signed();
        int v, s;
        logic [31:0] hi, lo;
        do_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, v, s, hi, lo);
        nvec++; if (hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL mult_m1 hi got %h want ffffffff", hi); end
        nvec++; if (lo !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL mult_m1 lo got %h want ffffffff", lo); end
        do_op(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, v, s, hi, lo);
        nvec++; if (hi !== 32'h4000_0000) begin nerr++; $display("FAIL mult_min hi got %h want 40000000", hi); end
        nvec++; if (lo !== 32'h0000_0000) begin nerr++; $display("FAIL mult_min lo got %h want 00000000", lo); end
        do_op(1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD, v, s, hi, lo);
        nvec++; if (hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL mult_7xm3 hi got %h want ffffffff", hi); end
        nvec++; if (lo !== 32'hFFFF_FFEB) begin nerr++; $display("FAIL mult_7xm3 lo got %h want ffffffeb", lo); end
        nvec++; if (v !== MulLat) begin nerr++; $display("FAIL mult_7xm3 valid_cycle got %0d want %0d", v, MulLat); end
    endtask

    task automatic test_div_zero();
        int v, s;
        logic [31:0] hi, lo;
        do_op(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, v, s, hi, lo);
        nvec++; if (v !== DivLat) begin nerr++; $display("FAIL divu0 valid_cycle got %0d want %0d", v, DivLat); end
        nvec++; if (lo !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL divu0 lo got %h want ffffffff", lo); end
        nvec++; if (hi !== 32'h0000_1234) begin nerr++; $display("FAIL divu0 hi got %h want 00001234", hi); end
        // -8 / 0: magnitude result q=ffffffff r=8, then signs fixed up
        do_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0, v, s, hi, lo);
        nvec++; if (lo !== 32'h0000_0001) begin nerr++; $display("FAIL div0_s lo got %h want 00000001", lo); end
        nvec++; if (hi !== 32'hFFFF_FFF8) begin nerr++; $display("FAIL div0_s hi got %h want fffffff8", hi); end
    endtask

    task automatic test_refresh();
        int v, s, nbad_stall, nbad_valid;
        logic [31:0] hi, lo;
        start_op(1'b1, 1'b0, 1'b1, 32'd5000, 32'd3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        md_if.refresh = 1'b1;
        @(negedge clk);
        nvec++; if (md_if.md_stall !== 1'b1) begin nerr++; $display("FAIL refresh_cycle stall got %b want 1", md_if.md_stall); end
        @(posedge clk); #1;
        md_if.refresh = 1'b0;
        clear_req();
        nbad_stall = 0;
        nbad_valid = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (md_if.md_stall) nbad_stall++;
            if (md_if.md_valid) nbad_valid++;
            @(posedge clk); #1;
        end
        nvec++; if (nbad_stall !== 0) begin nerr++; $display("FAIL abort stall_cycles got %0d want 0", nbad_stall); end
        nvec++; if (nbad_valid !== 0) begin nerr++; $display("FAIL abort valid_cycles got %0d want 0", nbad_valid); end
        nvec++; if (md_if.md_lo !== 32'h0000_0001) begin nerr++; $display("FAIL abort lo_kept got %h want 00000001", md_if.md_lo); end
        nvec++; if (md_if.md_hi !== 32'hFFFF_FFF8) begin nerr++; $display("FAIL abort hi_kept got %h want fffffff8", md_if.md_hi); end
        do_op(1'b1, 1'b0, 1'b1, 32'd100, 32'd7, v, s, hi, lo);
        nvec++; if (v !== DivLat) begin nerr++; $display("FAIL after_abort valid_cycle got %0d want %0d", v, DivLat); end
        nvec++; if (lo !== 32'd14) begin nerr++; $display("FAIL after_abort lo got %h want 0000000e", lo); end
        nvec++; if (hi !== 32'd2) begin nerr++; $display("FAIL after_abort hi got %h want 00000002", hi); end
    endtask

    task automatic test_back_to_back();
        int v, s, nval, nstall_done, nunstable;
        logic [31:0] hi, lo;
        start_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_valid(v, s);
        // First DONE cycle: hold for this and the next two cycles.
        md_if.pipe_hold = 1'b1;
        nval        = (v >= 0) ? 1 : 0;
        nstall_done = md_if.md_stall ? 1 : 0;
        nunstable   = 0;
        nvec++; if (md_if.md_lo !== 32'hFFFF_FFF2) begin nerr++; $display("FAIL hold lo got %h want fffffff2", md_if.md_lo); end
        nvec++; if (md_if.md_hi !== 32'hFFFF_FFFE) begin nerr++; $display("FAIL hold hi got %h want fffffffe", md_if.md_hi); end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 3) md_if.pipe_hold = 1'b0;
            @(negedge clk);
            if (md_if.md_valid) nval++;
            if (md_if.md_stall) nstall_done++;
            if (md_if.md_lo !== 32'hFFFF_FFF2 || md_if.md_hi !== 32'hFFFF_FFFE) nunstable++;
        end
        nvec++; if (nval !== 4) begin nerr++; $display("FAIL hold valid_cycles got %0d want 4", nval); end
        nvec++; if (nstall_done !== 0) begin nerr++; $display("FAIL hold stall_cycles got %0d want 0", nstall_done); end
        nvec++; if (nunstable !== 0) begin nerr++; $display("FAIL hold unstable_cycles got %0d want 0", nunstable); end
        @(posedge clk); #1;
        // The next op is presented the first cycle after the hold drops.
        do_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h10, v, s, hi, lo);
        nvec++; if (s !== DivLat) begin nerr++; $display("FAIL b2b stall_cycles got %0d want %0d", s, DivLat); end
        nvec++; if (v !== DivLat) begin nerr++; $display("FAIL b2b valid_cycle got %0d want %0d", v, DivLat); end
        nvec++; if (lo !== 32'h0FFF_FFFF) begin nerr++; $display("FAIL b2b lo got %h want 0fffffff", lo); end
        nvec++; if (hi !== 32'h0000_000F) begin nerr++; $display("FAIL b2b hi got %h want 0000000f", hi); end
    endtask

    initial begin
        clk             = 1'b0;
        resetn          = 1'b0;
        nvec            = 0;
        nerr            = 0;
        md_if.refresh   = 1'b0;
        md_if.pipe_hold = 1'b0;
        md_if.ex_mult   = 1'b0;
        md_if.ex_div    = 1'b0;
        md_if.ex_mdsign = 1'b0;
        md_if.ex_A      = '0;
        md_if.ex_B      = '0;
        test_reset();
        test_div_signed();
        test_multu();
        test_mult_signed();
        test_div_zero();
        test_refresh();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
